load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The unit SHALL have the parameter ADDR_W, default 32, meaning the width of byte addresses and data.
REQ-002 The unit SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The unit SHALL have the port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The unit SHALL have the port req_valid, input, 1 bit: a pipeline memory request is present.
REQ-005 The unit SHALL have the port req_ready, output, 1 bit: the request is accepted this cycle; low stalls the MEM stage.
REQ-006 The unit SHALL have the port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 The unit SHALL have the port req_funct3, input, 3 bits: RV32I width code (LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101).
REQ-008 The unit SHALL have the port req_addr, input, ADDR_W bits: byte address.
REQ-009 The unit SHALL have the port req_wdata, input, 32 bits: store data, right-aligned.
REQ-010 The unit SHALL have the port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 The unit SHALL have the port resp_rdata, output, 32 bits: sign- or zero-extended load result; 0 for stores and faults.
REQ-012 The unit SHALL have the port resp_misaligned, output, 1 bit: the completed request was misaligned; qualified by resp_valid.
REQ-013 The unit SHALL have the port resp_illegal, output, 1 bit: the completed request had an illegal funct3; qualified by resp_valid.
REQ-014 The unit SHALL have the ports mem_we and mem_re, outputs, 1 bit each: word write and read enables to the data memory.
REQ-015 The unit SHALL have the port mem_addr, output, 32 bits: word index, equal to {2'b00, addr[31:2]}.
REQ-016 The unit SHALL have the port mem_wdata, output, 32 bits: full word to write.
REQ-017 The unit SHALL have the port mem_rdata, input, 32 bits: combinational read data from the memory.

Function
REQ-018 The memory SHALL be modelled as word-only: write on the clk edge while mem_we=1; read combinational while mem_re=1.
REQ-019 The unit SHALL implement the states IDLE, ACCESS, RMW_WR and RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 On acceptance (req_valid and req_ready) in cycle N, the unit SHALL register addr, funct3, we and wdata, and enter ACCESS in N+1.
REQ-021 The unit SHALL detect a fault in IDLE: halfword with addr[0]=1 or word with addr[1:0]!=0 gives misaligned; load funct3 011/110/111 or store funct3 other than 000/001/010 gives illegal.
REQ-022 When a fault is detected, the unit SHALL go directly to RESP with no memory access; illegal SHALL take priority and resp_misaligned SHALL then be 0.
REQ-023 Load: in ACCESS, mem_re SHALL be 1; the unit SHALL extract byte or half lane addr[1:0], extend it per funct3, and register the result; RESP (resp_valid=1) SHALL occur in N+2.
REQ-024 SW: in ACCESS, mem_we SHALL be 1 with mem_wdata=wdata; RESP SHALL occur in N+2.
REQ-025 SB/SH: ACCESS SHALL assert mem_re and capture mem_rdata.
REQ-026 SB/SH: RMW_WR SHALL assert mem_we with the captured word in which only the addressed lane(s) are replaced; RESP SHALL occur in N+3.
REQ-027 RESP SHALL last exactly one cycle and then return to IDLE; a new request SHALL be acceptable in the cycle after RESP.
REQ-028 mem_we and mem_re SHALL never both be 1, and both SHALL be 0 in IDLE and RESP.
REQ-029 Requests presented while req_ready=0 SHALL be ignored and SHALL not be queued.

Reset
REQ-030 While rstn=0, the unit SHALL force state=IDLE, every output register to 0 and mem_we=mem_re=0 immediately, independent of clk.
REQ-031 A reset during ACCESS or RMW_WR SHALL abort the operation with no memory write and no resp_valid.
REQ-032 After reset release, req_ready SHALL be 1 in the first cycle.

Structure
REQ-033 The package lsu_pkg SHALL hold the state enum and the funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-034 The combinational sub-module lsu_align SHALL perform lane extraction and extension, and store-lane merging; the FSM SHALL remain in load_store_unit.

Verification
REQ-035 The bench SHALL check: memory word 5 = 0x8899AABB; LB at addr 0x15 -> resp in N+2, resp_rdata=0xFFFFFFAA; LBU -> 0x000000AA.
REQ-036 The bench SHALL check: SH 0x1234 at addr 0x16 over 0x8899AABB -> mem_re in N+1, mem_we in N+2 with 0x1234AABB, resp in N+3.
REQ-037 The bench SHALL check: SW 0xDEADBEEF at 0x20 -> mem_we in N+1, mem_addr=8, resp in N+2; a following LW returns 0xDEADBEEF.
REQ-038 The bench SHALL check: LW at 0x22 -> resp_misaligned=1 in N+1, resp_rdata=0, mem_re/mem_we never asserted.
REQ-039 The bench SHALL check: store funct3=100 -> resp_illegal=1, resp_misaligned=0, no memory access.
REQ-040 The bench SHALL check: rstn driven low during RMW_WR of SB -> mem_we drops at once, memory word unchanged, no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared FSM state type and RV32I load/store width codes for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RMW_WR,
    RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: load extraction with sign/zero extension and
// store-lane merging into a previously read memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] mask;

  assign shamt   = {lane_i, 3'b000};
  assign shifted = rdata_i >> shamt;

  // Load path: bring the addressed lane down to bit 0 and extend it.
  always_comb begin
    load_data_o = '0;
    case (funct3_i)
      F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data_o = {24'h000000, shifted[7:0]};
      F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data_o = {16'h0000, shifted[15:0]};
      F3_W:    load_data_o = rdata_i;
      default: load_data_o = '0;
    endcase
  end

  // Store path: replace only the addressed byte/half lane of the read word.
  always_comb begin
    mask     = '0;
    merged_o = rdata_i;
    case (funct3_i)
      F3_B: begin
        mask     = 32'h0000_00FF << shamt;
        merged_o = (rdata_i & ~mask) | ((wdata_i & 32'h0000_00FF) << shamt);
      end
      F3_H: begin
        mask     = 32'h0000_FFFF << shamt;
        merged_o = (rdata_i & ~mask) | ((wdata_i & 32'h0000_FFFF) << shamt);
      end
      F3_W:    merged_o = wdata_i;
      default: merged_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-only data memory: byte/half loads via lane
// extraction, byte/half stores via read-modify-write, faults answered directly.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misaligned,
  output logic              resp_illegal,
  output logic              mem_we,
  output logic              mem_re,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic              mem_we_q;
  logic              mem_re_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_mis_q;
  logic              resp_ill_q;

  logic              illegal;
  logic              misaligned;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  assign req_ready       = (state_q == IDLE);
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_misaligned = resp_mis_q;
  assign resp_illegal    = resp_ill_q;
  assign mem_we          = mem_we_q;
  assign mem_re          = mem_re_q;
  assign mem_addr        = 32'(addr_q >> 2);
  assign mem_wdata       = wdata_q;

  lsu_align u_align (
    .funct3_i    (funct3_q),
    .lane_i      (addr_q[1:0]),
    .rdata_i     (mem_rdata),
    .wdata_i     (wdata_q),
    .load_data_o (load_data),
    .merged_o    (merged)
  );

  // Classify the incoming request; illegal wins over misaligned downstream.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (req_we) begin
      illegal = !((req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W));
    end else begin
      illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    end
    case (req_funct3)
      F3_H, F3_HU: misaligned = req_addr[0];
      F3_W:        misaligned = (req_addr[1:0] != 2'b00);
      default:     misaligned = 1'b0;
    endcase
  end

  // Request FSM; memory enables and response fields are registered so that
  // they are set on entry to the state in which they must be visible.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      funct3_q     <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_mis_q   <= 1'b0;
      resp_ill_q   <= 1'b0;
    end else begin
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_mis_q   <= 1'b0;
      resp_ill_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            we_q     <= req_we;
            wdata_q  <= req_wdata;
            if (illegal || misaligned) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_ill_q   <= illegal;
              resp_mis_q   <= !illegal && misaligned;
            end else begin
              state_q <= ACCESS;
              if (req_we && (req_funct3 == F3_W)) begin
                mem_we_q <= 1'b1;
              end else begin
                mem_re_q <= 1'b1;
              end
            end
          end
        end
        ACCESS: begin
          if (we_q) begin
            if (funct3_q == F3_W) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
            end else begin
              // wdata_q is reused to hold the merged word for the write-back
              wdata_q  <= merged;
              mem_we_q <= 1'b1;
              state_q  <= RMW_WR;
            end
          end else begin
            resp_rdata_q <= load_data;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        RMW_WR: begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
